// File: rtl/dual_issue_fetch_queue_pkg.sv
// Shared processor constants for the fetch/decode boundary, plus small helpers
// used by the dual-issue fetch queue.
package dual_issue_fetch_queue_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_W      = 8;
  localparam int FQ_DEPTH  = 8;

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2,
    POP_OVER = 2'd3
  } pop_req_e;

  // Decode may request 3; the queue never retires more than two per cycle.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req);
    logic [1:0] res;
    case (pop_req_e'(req))
      POP_NONE: res = 2'd0;
      POP_ONE:  res = 2'd1;
      POP_TWO:  res = 2'd2;
      POP_OVER: res = 2'd2;
      default:  res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dual_issue_fetch_queue_if.sv
// Fetch-side push bus and decode-side pop bus of the dual-issue fetch queue.
// The queue uses the slave modport; the fetch/decode environment uses master.
interface dual_issue_fetch_queue_if #(
  parameter int DEPTH   = dual_issue_fetch_queue_pkg::FQ_DEPTH,
  parameter int INSTR_W = dual_issue_fetch_queue_pkg::INSTR_W,
  parameter int PC_W    = dual_issue_fetch_queue_pkg::PC_W
);
  logic                   flush;
  logic                   in_valid1;
  logic                   in_valid2;
  logic [INSTR_W-1:0]     in_instr1;
  logic [INSTR_W-1:0]     in_instr2;
  logic [PC_W-1:0]        in_pc;
  logic                   in_ready;
  logic                   out_valid1;
  logic                   out_valid2;
  logic [INSTR_W-1:0]     out_instr1;
  logic [INSTR_W-1:0]     out_instr2;
  logic [PC_W-1:0]        out_pc1;
  logic [PC_W-1:0]        out_pc2;
  logic [1:0]             out_pop;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output flush, in_valid1, in_valid2, in_instr1, in_instr2, in_pc, out_pop,
    input  in_ready, out_valid1, out_valid2, out_instr1, out_instr2,
           out_pc1, out_pc2, count
  );

  modport slave (
    input  flush, in_valid1, in_valid2, in_instr1, in_instr2, in_pc, out_pop,
    output in_ready, out_valid1, out_valid2, out_instr1, out_instr2,
           out_pc1, out_pc2, count
  );
endinterface

// File: rtl/dual_issue_fetch_queue_fq_storage.sv
// Entry array for the fetch queue: two write ports and two asynchronous read
// ports, each pair addressing consecutive entries, with async active-low clear.
module fq_storage #(
  parameter int DEPTH = 8,
  parameter int W     = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we1,
  input  logic                     we2,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata1,
  input  logic [W-1:0]             wdata2,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata1,
  output logic [W-1:0]             rdata2
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DEPTH-1:0][W-1:0] mem_d;
  logic [AW-1:0]           waddr2_s;
  logic [AW-1:0]           raddr2_s;

  assign waddr2_s = waddr + AW'(1);
  assign raddr2_s = raddr + AW'(1);

  // Next array contents: slot 1 at waddr, slot 2 at the following entry.
  always_comb begin
    mem_d = mem_q;
    if (we1) begin
      mem_d[waddr] = wdata1;
    end else begin
      mem_d = mem_q;
    end
    if (we2) begin
      mem_d[waddr2_s] = wdata2;
    end
  end

  // Array register with immediate clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = mem_q[raddr];
  assign rdata2 = mem_q[raddr2_s];

endmodule

// File: rtl/dual_issue_fetch_queue.sv
// Dual-issue fetch queue: accepts up to two instructions per cycle from fetch
// and presents the two oldest to decode, which retires 0..2 per cycle.
module dual_issue_fetch_queue #(
  parameter int DEPTH   = dual_issue_fetch_queue_pkg::FQ_DEPTH,
  parameter int INSTR_W = dual_issue_fetch_queue_pkg::INSTR_W,
  parameter int PC_W    = dual_issue_fetch_queue_pkg::PC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  dual_issue_fetch_queue_if.slave fq
);
  import dual_issue_fetch_queue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = INSTR_W + PC_W;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          ready_s;
  logic          push_s;
  logic          we2_s;
  logic [1:0]    pop_req_s;
  logic [CW-1:0] npush_s;
  logic [CW-1:0] npop_s;
  logic [EW-1:0] wdata1_s, wdata2_s, rdata1_s, rdata2_s;

  // Readiness only looks at registered occupancy; no credit for same-cycle pops.
  assign ready_s  = (count_q <= CW'(DEPTH - 2));
  assign wdata1_s = {fq.in_instr1, fq.in_pc};
  assign wdata2_s = {fq.in_instr2, fq.in_pc + PC_W'(1)};

  // Push/pop amounts and next pointer/count state; flush overrides everything.
  always_comb begin
    pop_req_s = clamp_pop(fq.out_pop);
    push_s    = fq.in_valid1 && ready_s && !fq.flush;
    we2_s     = push_s && fq.in_valid2;
    npush_s   = '0;
    npop_s    = '0;
    if (push_s) begin
      npush_s = fq.in_valid2 ? CW'(2) : CW'(1);
    end else begin
      npush_s = '0;
    end
    if (CW'(pop_req_s) > count_q) begin
      npop_s = count_q;
    end else begin
      npop_s = CW'(pop_req_s);
    end
    if (fq.flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + npush_s - npop_s;
      rd_ptr_d = rd_ptr_q + PW'(npop_s);
      wr_ptr_d = wr_ptr_q + PW'(npush_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_storage (
    .clk    (clk),
    .rst    (rst),
    .we1    (push_s),
    .we2    (we2_s),
    .waddr  (wr_ptr_q),
    .wdata1 (wdata1_s),
    .wdata2 (wdata2_s),
    .raddr  (rd_ptr_q),
    .rdata1 (rdata1_s),
    .rdata2 (rdata2_s)
  );

  assign fq.in_ready   = ready_s;
  assign fq.out_valid1 = (count_q >= CW'(1));
  assign fq.out_valid2 = (count_q >= CW'(2));
  assign fq.out_instr1 = rdata1_s[EW-1:PC_W];
  assign fq.out_instr2 = rdata2_s[EW-1:PC_W];
  assign fq.out_pc1    = rdata1_s[PC_W-1:0];
  assign fq.out_pc2    = rdata2_s[PC_W-1:0];
  assign fq.count      = count_q;

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Directed bench for dual_issue_fetch_queue: hand-computed occupancy, ordering,
// PC wrap, clamped pops, flush and async reset checks.
module tb_dual_issue_fetch_queue;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  dual_issue_fetch_queue_if #(.DEPTH(8), .INSTR_W(32), .PC_W(8)) fq_if ();

  dual_issue_fetch_queue #(.DEPTH(8), .INSTR_W(32), .PC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word tied to its PC so ordering errors show up in data too.
  function automatic logic [31:0] instr_of(input logic [7:0] pc);
    return {24'hC0DE00, pc};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic v2, input logic [7:0] pc,
                       input logic [1:0] pop, input logic fl);
    fq_if.in_valid1 = v1;
    fq_if.in_valid2 = v2;
    fq_if.in_pc     = pc;
    fq_if.in_instr1 = instr_of(pc);
    fq_if.in_instr2 = instr_of(pc + 8'd1);
    fq_if.out_pop   = pop;
    fq_if.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic head(input string tag, input logic [3:0] cnt,
                      input logic [7:0] pc1, input logic [7:0] pc2);
    check_eq({tag, ".count"}, 64'(fq_if.count), 64'(cnt));
    check_eq({tag, ".pc1"},   64'(fq_if.out_pc1), 64'(pc1));
    check_eq({tag, ".pc2"},   64'(fq_if.out_pc2), 64'(pc2));
    check_eq({tag, ".instr1"}, 64'(fq_if.out_instr1), 64'(instr_of(pc1)));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    check_eq("rst.count",  64'(fq_if.count), 64'd0);
    check_eq("rst.valid1", 64'(fq_if.out_valid1), 64'd0);
    check_eq("rst.valid2", 64'(fq_if.out_valid2), 64'd0);
    check_eq("rst.ready",  64'(fq_if.in_ready), 64'd1);
    check_eq("rst.instr",  64'({fq_if.out_instr1, fq_if.out_instr2}), 64'd0);
    check_eq("rst.pc",     64'({fq_if.out_pc1, fq_if.out_pc2}), 64'd0);
    rst = 1'b1;
    tick();
    check_eq("idle.count", 64'(fq_if.count), 64'd0);

    // First pair, visible one cycle later.
    drive(1'b1, 1'b1, 8'h10, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    head("pair", 4'd2, 8'h10, 8'h11);
    check_eq("pair.instr2", 64'(fq_if.out_instr2), 64'(32'hC0DE0011));
    check_eq("pair.valid2", 64'(fq_if.out_valid2), 64'd1);

    // Fill to 8.
    drive(1'b1, 1'b1, 8'h12, 2'd0, 1'b0); tick();
    drive(1'b1, 1'b1, 8'h14, 2'd0, 1'b0); tick();
    check_eq("fill6.ready", 64'(fq_if.in_ready), 64'd1);
    drive(1'b1, 1'b1, 8'h16, 2'd0, 1'b0); tick();
    check_eq("full.ready", 64'(fq_if.in_ready), 64'd0);
    head("full", 4'd8, 8'h10, 8'h11);
    drive(1'b1, 1'b1, 8'h50, 2'd0, 1'b0); tick();
    head("refused", 4'd8, 8'h10, 8'h11);
    drive(1'b0, 1'b0, 8'h00, 2'd2, 1'b0); tick();
    check_eq("pop2.ready", 64'(fq_if.in_ready), 64'd1);
    head("pop2", 4'd6, 8'h12, 8'h13);

    // count==7: single push refused.
    drive(1'b1, 1'b0, 8'h60, 2'd0, 1'b0); tick();
    check_eq("c7.count", 64'(fq_if.count), 64'd7);
    check_eq("c7.ready", 64'(fq_if.in_ready), 64'd0);
    drive(1'b1, 1'b0, 8'h61, 2'd0, 1'b0); tick();
    check_eq("c7.refused", 64'(fq_if.count), 64'd7);
    drive(1'b0, 1'b0, 8'h00, 2'd2, 1'b0); tick();
    head("c5", 4'd5, 8'h14, 8'h15);

    // Flush wins over a same-cycle push.
    drive(1'b1, 1'b1, 8'h70, 2'd1, 1'b1); tick();
    drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    check_eq("flush.count",  64'(fq_if.count), 64'd0);
    check_eq("flush.valid1", 64'(fq_if.out_valid1), 64'd0);
    check_eq("flush.ready",  64'(fq_if.in_ready), 64'd1);
    tick();
    check_eq("flush.hold", 64'(fq_if.count), 64'd0);

    // Push 2 / pop 1 across pointer and PC wrap.
    drive(1'b1, 1'b1, 8'hFC, 2'd0, 1'b0); tick();
    head("w0", 4'd2, 8'hFC, 8'hFD);
    drive(1'b1, 1'b1, 8'hFE, 2'd1, 1'b0); tick();
    head("w1", 4'd3, 8'hFD, 8'hFE);
    drive(1'b1, 1'b1, 8'h00, 2'd1, 1'b0); tick();
    head("w2", 4'd4, 8'hFE, 8'hFF);
    drive(1'b1, 1'b1, 8'h02, 2'd1, 1'b0); tick();
    head("w3", 4'd5, 8'hFF, 8'h00);
    drive(1'b1, 1'b1, 8'h04, 2'd1, 1'b0); tick();
    head("w4", 4'd6, 8'h00, 8'h01);
    drive(1'b0, 1'b0, 8'h00, 2'd2, 1'b0); tick();
    head("w5", 4'd4, 8'h02, 8'h03);
    drive(1'b0, 1'b0, 8'h00, 2'd2, 1'b0); tick();
    head("w6", 4'd2, 8'h04, 8'h05);

    // Over-pop clamp with simultaneous push.
    drive(1'b0, 1'b0, 8'h00, 2'd1, 1'b0); tick();
    check_eq("c1.count", 64'(fq_if.count), 64'd1);
    check_eq("c1.pc1",   64'(fq_if.out_pc1), 64'h05);
    drive(1'b1, 1'b1, 8'h80, 2'd2, 1'b0); tick();
    head("clamp", 4'd2, 8'h80, 8'h81);
    drive(1'b0, 1'b0, 8'h00, 2'd3, 1'b0); tick();
    check_eq("pop3.count",  64'(fq_if.count), 64'd0);
    check_eq("pop3.valid1", 64'(fq_if.out_valid1), 64'd0);
    drive(1'b0, 1'b1, 8'h88, 2'd0, 1'b0); tick();
    check_eq("v2only.count", 64'(fq_if.count), 64'd0);

    // Async reset asserted mid-cycle during a push.
    drive(1'b1, 1'b1, 8'h90, 2'd0, 1'b0); tick();
    head("prerst", 4'd2, 8'h90, 8'h91);
    drive(1'b1, 1'b1, 8'hA0, 2'd0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("arst.count", 64'(fq_if.count), 64'd0);
    check_eq("arst.pc1",   64'(fq_if.out_pc1), 64'd0);
    check_eq("arst.instr1", 64'(fq_if.out_instr1), 64'd0);
    check_eq("arst.ready", 64'(fq_if.in_ready), 64'd1);
    @(negedge clk);
    check_eq("arst.hold", 64'(fq_if.count), 64'd0);
    drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    rst = 1'b1;
    tick();
    check_eq("post.count", 64'(fq_if.count), 64'd0);
    check_eq("post.valid1", 64'(fq_if.out_valid1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
